init_reg_bank: RTL
==================

# init_reg_bank

Parametrised bank of DEPTH state registers, each WIDTH bits, all loaded with a fixed INIT value at reset, as the generalisation of a single constructor-initialised register with one getter. It adds write, saturating or wrapping increment, registered reads and per-entry dirty tracking. It sits beside translated modules as their shared configuration/counter store and is read through a one-cycle-latency port.

## Interface
- WIDTH, 8, bit width of each entry (1..32)
- DEPTH, 4, number of entries (1..64, need not be a power of two)
- INIT, 7, reset value of every entry, truncated to WIDTH bits
- SAT, 1, increment mode: 1 saturates at all-ones, 0 wraps to 0
- ADDR_W, $clog2(DEPTH) (min 1), address width, derived, not overridden
- clock  in  1  sole clock, all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- inc_en  in  1  increment strobe
- inc_addr  in  ADDR_W  increment address
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  rd_data valid for this cycle
- clr_dirty  in  1  clear all dirty bits
- dirty  out  DEPTH  bit i set when entry i modified since reset/clear

## Operation
- Reset (reset_n low at edge): all entries = INIT; rd_data = 0; rd_valid = 0; dirty = 0. Reset overrides every other input that cycle.
- Write: wr_en with wr_addr < DEPTH sets entry to wr_data and sets dirty[wr_addr].
- Increment: inc_en with inc_addr < DEPTH adds 1. If SAT=1 and entry is all-ones, the value stays and dirty is still set. If SAT=0, all-ones wraps to 0. Dirty is set in both cases.
- Same-cycle wr and inc to one address: write wins, the increment is dropped. Different addresses: both apply.
- Out-of-range addresses (≥ DEPTH): write and increment ignored, no dirty change. A read returns rd_data = 0 with rd_valid = 1.
- Read: rd_en at edge t gives rd_data = entry value before edge t updates, and rd_valid = 1 during cycle t+1. There is no write-to-read bypass. rd_en low gives rd_valid = 0 and rd_data holds its last value.
- clr_dirty: clears all dirty bits. A same-cycle write or increment still sets its own bit (set wins over clear).
- No handshake back-pressure; every strobe is accepted every cycle.

## Timing
- Write/increment: visible in the entry after 1 edge, and via the read port 2 edges after the strobe.
- Read latency: exactly 1 cycle; a new read can be issued every cycle.
- dirty updates on the same edge as the modifying strobe.
- Reset mid-read: rd_valid = 0 in the cycle after the reset edge, and the pending read is discarded.
- All outputs are registers; there are no combinational paths from inputs to outputs.

## Structure
- Package init_reg_bank_pkg: SAT_MODE and WRAP_MODE constants, and an ADDR_W helper function (clog2 with min 1).
- Sub-module reg_cell: one WIDTH-bit entry with INIT/SAT parameters, write/inc/reset logic and its dirty bit, instantiated DEPTH times in a generate loop.
- Top level: address decode, out-of-range guard, read mux and output registers.

## Test plan
- Reset then read each address, defaults (WIDTH=8, DEPTH=4, INIT=7) -> rd_data = 7 one cycle after each rd_en; dirty = 4'b0000.
- Write 8'hA5 to addr 2, read addr 2 in the same cycle then the next cycle -> first read 7, second A5; dirty = 4'b0100.
- SAT=1: write 8'hFE to addr 1, then 3 inc cycles -> reads FF; SAT=0, same stimulus -> reads 01.
- Same-cycle wr_en(addr 0, 8'h10) and inc_en(addr 0), then clr_dirty with inc_en(addr 3) -> entry 0 = 10, entry 3 = 08, dirty = 4'b1000.
- DEPTH=3: write 8'h55 to addr 3, read addr 3 -> rd_data = 0, rd_valid = 1; entries 0..2 unchanged at 7; dirty = 0.
- Assert reset_n low for one cycle while rd_en is high after several writes -> rd_valid = 0 next cycle; all entries 7; dirty = 0.

Source files
------------

// File: rtl/init_reg_bank_pkg.sv
// Shared constants and the address-width helper for the init_reg_bank register store.
package init_reg_bank_pkg;

  localparam int SAT_MODE  = 1;
  localparam int WRAP_MODE = 0;

  // clog2 with a floor of 1 so a single-entry bank still has an address bit.
  function automatic int addr_w(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/reg_cell.sv
// One bank entry: INIT on reset, write beats increment, sticky dirty bit.
module reg_cell
  import init_reg_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int INIT  = 7,
  parameter int SAT   = SAT_MODE
)(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr,
  input  logic             inc,
  input  logic             clr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] value,
  output logic             dirty
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      value <= INIT_V;
      dirty <= 1'b0;
    end else begin
      if (wr)
        value <= wr_data;
      else if (inc && !((SAT != 0) && (&value)))
        value <= value + WIDTH'(1);
      // A modification on the same edge as a clear keeps its own bit set.
      if (wr || inc)
        dirty <= 1'b1;
      else if (clr)
        dirty <= 1'b0;
    end
  end

endmodule

// File: rtl/init_reg_bank.sv
// Bank of DEPTH INIT-loaded registers with write, increment, dirty tracking and a registered read port.
module init_reg_bank
  import init_reg_bank_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  parameter  int INIT   = 7,
  parameter  int SAT    = SAT_MODE,
  localparam int ADDR_W = addr_w(DEPTH)
)(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              inc_en,
  input  logic [ADDR_W-1:0] inc_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              clr_dirty,
  output logic [DEPTH-1:0]  dirty
);

  logic [DEPTH-1:0][WIDTH-1:0] values;
  logic [WIDTH-1:0]            rd_mux;

  // Addresses >= DEPTH match no cell, so out-of-range strobes fall away here.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic wr_hit, inc_hit;
    assign wr_hit  = wr_en && (wr_addr == ADDR_W'(i));
    assign inc_hit = inc_en && (inc_addr == ADDR_W'(i)) && !wr_hit;

    reg_cell #(
      .WIDTH (WIDTH),
      .INIT  (INIT),
      .SAT   (SAT)
    ) u_cell (
      .clock   (clock),
      .reset_n (reset_n),
      .wr      (wr_hit),
      .inc     (inc_hit),
      .clr     (clr_dirty),
      .wr_data (wr_data),
      .value   (values[i]),
      .dirty   (dirty[i])
    );
  end

  // Unmatched (out-of-range) read addresses return zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_addr == ADDR_W'(i)) rd_mux = values[i];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule
